// File: rtl/multi_dataflow_job_sched.sv
// multi_dataflow_job_sched: FIFO job dispatcher with beat counting, drain wait and no-progress watchdog
module multi_dataflow_job_sched #(
  parameter int N_CONTEXT = 2,
  parameter int CTX_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
  parameter int CNT_W = 32,
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [CTX_W-1:0] push_ctx_i,
  input  logic [CNT_W-1:0] push_limit_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  output logic             start_o,
  output logic [CTX_W-1:0] start_ctx_o,
  input  logic             out_valid_i,
  input  logic             out_ready_i,
  input  logic             engine_idle_i,
  output logic             abort_o,
  output logic             done_o,
  output logic [CTX_W-1:0] done_ctx_o,
  output logic             timeout_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CTX_W:0]   pending_o
);
  localparam int PW = CTX_W + 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_DONE, S_ABORT} state_t;
  state_t           r_state;
  logic [CTX_W-1:0] r_q_ctx [N_CONTEXT];
  logic [CNT_W-1:0] r_q_lim [N_CONTEXT];
  logic [CTX_W-1:0] r_wp, r_rp, r_ctx;
  logic [PW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_lim, r_beat;
  logic [TMO_W-1:0] r_wdog;
  logic             r_start, r_done, r_abort, r_err;
  logic             w_push, w_pop, w_beat, w_hit;
  logic [TMO_W-1:0] w_wdog_inc;
  logic [CTX_W-1:0] w_wp_nxt, w_rp_nxt;

  assign push_ready_o = r_cnt != PW'(N_CONTEXT);
  assign w_push       = push_valid_i & push_ready_o;
  assign w_pop        = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_beat       = out_valid_i & out_ready_i;
  // watchdog fires on the cycle the stall count would reach the live limit
  assign w_hit        = (tmo_limit_i != '0) && (r_wdog == tmo_limit_i - TMO_W'(1));
  assign w_wdog_inc   = (&r_wdog) ? r_wdog : r_wdog + TMO_W'(1);
  assign w_wp_nxt     = (r_wp == CTX_W'(N_CONTEXT - 1)) ? '0 : r_wp + CTX_W'(1);
  assign w_rp_nxt     = (r_rp == CTX_W'(N_CONTEXT - 1)) ? '0 : r_rp + CTX_W'(1);

  assign start_o     = r_start;
  assign done_o      = r_done;
  assign abort_o     = r_abort;
  assign timeout_o   = r_abort;
  assign err_o       = r_err;
  assign busy_o      = r_state != S_IDLE;
  assign pending_o   = r_cnt;
  assign start_ctx_o = r_ctx;
  assign done_ctx_o  = r_ctx;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_ctx   <= '0;
      r_lim   <= '0;
      r_beat  <= '0;
      r_wdog  <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_push) begin
        r_q_ctx[r_wp] <= push_ctx_i;
        r_q_lim[r_wp] <= push_limit_i;
        r_wp          <= w_wp_nxt;
      end
      if (w_pop) r_rp <= w_rp_nxt;
      r_cnt <= r_cnt + PW'(w_push) - PW'(w_pop);
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_ctx   <= r_q_ctx[r_rp];
          r_lim   <= r_q_lim[r_rp];
          r_beat  <= '0;
          r_wdog  <= '0;
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: r_state <= (r_lim == '0) ? S_DRAIN : S_RUN;
        S_RUN: if (w_beat) begin
          r_beat <= r_beat + CNT_W'(1);
          r_wdog <= '0;
          if (r_beat == r_lim - CNT_W'(1)) r_state <= S_DRAIN;
        end else if (w_hit) begin
          r_abort <= 1'b1;
          r_err   <= 1'b1;
          r_state <= S_ABORT;
        end else r_wdog <= w_wdog_inc;
        S_DRAIN: if (engine_idle_i) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else if (w_hit) begin
          r_abort <= 1'b1;
          r_err   <= 1'b1;
          r_state <= S_ABORT;
        end else r_wdog <= w_wdog_inc;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_dataflow_job_sched.sv
// tb_multi_dataflow_job_sched: directed scenarios plus random traffic against a job-level reference model
module tb_multi_dataflow_job_sched;
  localparam int N  = 2;
  localparam int CW = 1;
  localparam int LW = 32;
  localparam int TW = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni, clear_i, push_valid_i, push_ready_o;
  logic [CW-1:0] push_ctx_i, start_ctx_o, done_ctx_o;
  logic [LW-1:0] push_limit_i;
  logic [TW-1:0] tmo_limit_i;
  logic          start_o, out_valid_i, out_ready_i, engine_idle_i;
  logic          abort_o, done_o, timeout_o, err_o, busy_o;
  logic [CW:0]   pending_o;

  multi_dataflow_job_sched #(.N_CONTEXT(N), .CTX_W(CW), .CNT_W(LW), .TMO_W(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_ctx_i(push_ctx_i), .push_limit_i(push_limit_i), .tmo_limit_i(tmo_limit_i),
    .start_o(start_o), .start_ctx_o(start_ctx_o),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .engine_idle_i(engine_idle_i),
    .abort_o(abort_o), .done_o(done_o), .done_ctx_o(done_ctx_o), .timeout_o(timeout_o),
    .err_o(err_o), .busy_o(busy_o), .pending_o(pending_o)
  );

  typedef struct {int ctx; longint lim;} job_t;
  typedef enum {P_IDLE, P_START, P_RUN, P_DRAIN, P_DONE, P_ABORT} ph_t;
  job_t mq[$];
  job_t cur;
  ph_t  ph;
  int   beats, stall, n_chk, n_err;
  bit   m_err, m_acc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock edge of job-level behaviour, using the inputs that were present at the edge
  task automatic model();
    bit pop, hit, beat;
    m_acc = push_valid_i && (mq.size() < N);
    if (!rst_ni || clear_i) begin
      mq.delete();
      ph = P_IDLE; m_err = 0; m_acc = 0; beats = 0; stall = 0;
      return;
    end
    pop  = (ph == P_IDLE) && (mq.size() != 0);
    beat = out_valid_i && out_ready_i;
    hit  = (tmo_limit_i != 0) && (stall + 1 == int'(tmo_limit_i));
    if (m_acc) mq.push_back('{ctx: int'(push_ctx_i), lim: longint'(push_limit_i)});
    case (ph)
      P_IDLE: if (pop) begin cur = mq.pop_front(); beats = 0; stall = 0; ph = P_START; end
      P_START: ph = (cur.lim == 0) ? P_DRAIN : P_RUN;
      P_RUN: begin
        if (beat) begin
          beats++; stall = 0;
          if (beats == cur.lim) ph = P_DRAIN;
        end else if (hit) begin ph = P_ABORT; m_err = 1; end
        else if (stall < 65535) stall++;
      end
      P_DRAIN: begin
        if (engine_idle_i) ph = P_DONE;
        else if (hit) begin ph = P_ABORT; m_err = 1; end
        else if (stall < 65535) stall++;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic compare();
    check("start", start_o, ph == P_START);
    check("done", done_o, ph == P_DONE);
    check("abort", abort_o, ph == P_ABORT);
    check("timeout", timeout_o, ph == P_ABORT);
    check("busy", busy_o, ph != P_IDLE);
    check("err", err_o, m_err);
    check("pending", pending_o, mq.size());
    check("push_ready", push_ready_o, mq.size() < N);
    if (ph == P_DONE) check("done_ctx", done_ctx_o, cur.ctx);
    if (ph != P_IDLE) check("start_ctx", start_ctx_o, cur.ctx);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    model();
    compare();
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic push_job(int ctx, int lim);
    bit ok = 0;
    push_valid_i = 1'b1;
    push_ctx_i   = CW'(ctx);
    push_limit_i = LW'(lim);
    for (int k = 0; k < 200 && !ok; k++) begin
      cyc();
      ok = m_acc;
    end
    check("push_accept", ok, 1'b1);
    push_valid_i = 1'b0;
  endtask

  task automatic stream(bit v, bit r, bit idle);
    out_valid_i = v; out_ready_i = r; engine_idle_i = idle;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_ni = 1'b0; clear_i = 1'b0; push_valid_i = 1'b0; push_ctx_i = '0;
    push_limit_i = '0; tmo_limit_i = '0;
    stream(0, 0, 0);
    run(2);
    check("rst_start_ctx", start_ctx_o, 0);
    check("rst_done_ctx", done_ctx_o, 0);
    rst_ni = 1'b1;
    run(1);
    // single job with four beats
    push_job(1, 4);
    run(1);
    stream(1, 1, 0);
    run(5);
    stream(0, 0, 1);
    run(3);
    // fill the queue behind a stalled job, then a fourth push must wait for a pop
    stream(0, 1, 0);
    push_job(0, 2);
    push_job(1, 2);
    push_job(0, 1);
    run(2);
    stream(1, 1, 1);
    push_job(1, 3);
    run(30);
    // watchdog expiry after one beat, next job then runs
    tmo_limit_i = 16'd8;
    stream(0, 1, 0);
    push_job(1, 3);
    push_job(0, 1);
    run(2);
    stream(1, 1, 0);
    run(1);
    stream(0, 1, 0);
    run(12);
    stream(1, 1, 1);
    run(10);
    // zero-limit job only waits for idle
    tmo_limit_i = '0;
    stream(0, 0, 0);
    push_job(1, 0);
    run(4);
    engine_idle_i = 1'b1;
    run(4);
    // beat lands on the watchdog's final cycle
    tmo_limit_i = 16'd4;
    stream(0, 1, 0);
    push_job(0, 3);
    run(2);
    run(3);
    out_valid_i = 1'b1; run(1); out_valid_i = 1'b0;
    run(3);
    out_valid_i = 1'b1; run(1); out_valid_i = 1'b0;
    // disabled watchdog tolerates a long stall
    tmo_limit_i = '0;
    run(1000);
    stream(1, 1, 1);
    run(6);
    // clear in the middle of a run with two jobs queued
    stream(0, 1, 0);
    push_job(0, 5);
    push_job(1, 5);
    push_job(0, 5);
    run(3);
    clear_i = 1'b1; run(1); clear_i = 1'b0;
    run(3);
    stream(1, 1, 1);
    push_job(1, 2);
    run(8);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      push_valid_i = $urandom_range(0, 3) == 0;
      push_ctx_i   = CW'($urandom_range(0, N - 1));
      push_limit_i = LW'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0)
        tmo_limit_i = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 10));
      out_valid_i   = $urandom_range(0, 9) < 4;
      out_ready_i   = $urandom_range(0, 9) < 7;
      engine_idle_i = $urandom_range(0, 1) == 1;
      clear_i       = $urandom_range(0, 199) == 0;
      rst_ni        = $urandom_range(0, 499) != 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
